// File: rtl/spi_master.sv
// SPI mode-0 initiator: streams bytes from a valid/ready source onto SCLK/MOSI,
// framing CS_N with a last-byte marker and a one-byte holding register.
module spi_master #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tx_valid_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_last_in,
  output logic       tx_ready_out,
  output logic       spi_sclk_out,
  output logic       spi_mosi_out,
  output logic       spi_cs_n_out,
  output logic       busy_out
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_RLD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_RLD = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_SHIFT, S_WAIT, S_TRAIL, S_GAP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hold_full, hold_last;
  logic [7:0]       hold_data;
  logic [7:0]       sh_data;
  logic             sh_last;
  logic [2:0]       bit_cnt;
  logic             sclk, mosi, cs_n, busy;
  logic             sclk_nxt, mosi_nxt, cs_n_nxt;
  logic             load, shift_en, accept, tick, boundary;

  assign accept       = tx_valid_in && !hold_full;
  assign tick         = (cnt == '0);
  // The byte boundary is the falling SCLK edge that ends the 8th bit.
  assign boundary     = (state == S_SHIFT) && tick && sclk && (bit_cnt == 3'd7);
  assign tx_ready_out = !hold_full;
  assign spi_sclk_out = sclk;
  assign spi_mosi_out = mosi;
  assign spi_cs_n_out = cs_n;
  assign busy_out     = busy;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      sh_last   <= 1'b0;
      bit_cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sclk  <= sclk_nxt;
      mosi  <= mosi_nxt;
      cs_n  <= cs_n_nxt;
      busy  <= (state_nxt != S_IDLE);
      if (accept) begin
        hold_full <= 1'b1;
        hold_last <= tx_last_in;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        sh_last <= hold_last;
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Payload registers carry no reset; the full flag qualifies them.
  always_ff @(posedge clk_in) begin
    if (accept) hold_data <= tx_data_in;
    if (load)
      sh_data <= hold_data;
    else if (shift_en)
      sh_data <= {sh_data[6:0], 1'b0};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hold_full) state_nxt = S_LEAD;
      S_LEAD:  if (tick) state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (boundary) begin
          if (sh_last)        state_nxt = S_TRAIL;
          else if (hold_full) state_nxt = S_SHIFT;
          else                state_nxt = S_WAIT;
        end
      end
      S_WAIT:  if (hold_full) state_nxt = S_LEAD;
      S_TRAIL: if (tick) state_nxt = S_GAP;
      S_GAP:   if (tick) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    shift_en = 1'b0;
    sclk_nxt = sclk;
    mosi_nxt = mosi;
    cs_n_nxt = cs_n;
    cnt_nxt  = tick ? cnt : cnt - 1'b1;
    case (state)
      S_IDLE: begin
        cs_n_nxt = 1'b1;
        sclk_nxt = 1'b0;
        mosi_nxt = 1'b0;
        if (hold_full) begin
          load     = 1'b1;
          cs_n_nxt = 1'b0;
          mosi_nxt = hold_data[7];
          cnt_nxt  = DIV_RLD;
        end
      end
      S_LEAD: begin
        if (tick) begin
          sclk_nxt = 1'b1;
          cnt_nxt  = DIV_RLD;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          sclk_nxt = !sclk;
          cnt_nxt  = DIV_RLD;
          if (sclk) begin
            if (bit_cnt != 3'd7) begin
              shift_en = 1'b1;
              mosi_nxt = sh_data[6];
            end else if (!sh_last && hold_full) begin
              // Back-to-back byte: reload with no SCLK gap.
              load     = 1'b1;
              mosi_nxt = hold_data[7];
            end
          end
        end
      end
      S_WAIT: begin
        sclk_nxt = 1'b0;
        if (hold_full) begin
          load     = 1'b1;
          mosi_nxt = hold_data[7];
          cnt_nxt  = DIV_RLD;
        end
      end
      S_TRAIL: begin
        sclk_nxt = 1'b0;
        if (tick) begin
          cs_n_nxt = 1'b1;
          cnt_nxt  = GAP_RLD;
        end
      end
      S_GAP: begin
        if (tick) cnt_nxt = DIV_RLD;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=2/CS_GAP=2 and CLK_DIV=1/CS_GAP=3)
// observed by an SPI receiver model that records frames, edges and bytes.
module tb_spi_master;

  logic       clk, rst;
  logic [1:0] valid_v, last_v;
  logic [7:0] data_v [2];
  logic [1:0] ready_v, sclk_v, mosi_v, cs_v, busy_v;

  int tests, fails;

  // receiver model state
  logic [1:0] cs_prev, sclk_prev, mosi_prev;
  logic [7:0] sh [2];
  int         nb [2];
  logic [7:0] rx_mem [2][256];
  int         rx_n [2];
  int         rise_t [2][2048];
  int         rise_n [2];
  int         fall_t [2][64];
  int         gap_len [2][64];
  int         fall_n [2];
  int         cs_len [2][64];
  int         sclk_at_rise [2][64];
  int         len_n [2];
  int         last_csrise [2];
  int         viol [2];

  spi_master #(.CLK_DIV(2), .CS_GAP(2)) dut_a (
    .clk_in(clk), .rst_in(rst), .tx_valid_in(valid_v[0]), .tx_data_in(data_v[0]),
    .tx_last_in(last_v[0]), .tx_ready_out(ready_v[0]), .spi_sclk_out(sclk_v[0]),
    .spi_mosi_out(mosi_v[0]), .spi_cs_n_out(cs_v[0]), .busy_out(busy_v[0]));

  spi_master #(.CLK_DIV(1), .CS_GAP(3)) dut_b (
    .clk_in(clk), .rst_in(rst), .tx_valid_in(valid_v[1]), .tx_data_in(data_v[1]),
    .tx_last_in(last_v[1]), .tx_ready_out(ready_v[1]), .spi_sclk_out(sclk_v[1]),
    .spi_mosi_out(mosi_v[1]), .spi_cs_n_out(cs_v[1]), .busy_out(busy_v[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int now_c();
    return int'($time / 10);
  endfunction

  initial begin
    cs_prev = 2'b11; sclk_prev = 2'b00; mosi_prev = 2'b00;
    for (int i = 0; i < 2; i++) begin
      sh[i] = 8'h00; nb[i] = 0; rx_n[i] = 0; rise_n[i] = 0; fall_n[i] = 0;
      len_n[i] = 0; last_csrise[i] = 0; viol[i] = 0;
    end
  end

  // Receiver: samples pins on the falling clk edge, between active edges.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs_prev[i] && !cs_v[i] && fall_n[i] < 64) begin
        fall_t[i][fall_n[i]]  <= now_c();
        gap_len[i][fall_n[i]] <= now_c() - last_csrise[i];
        fall_n[i] <= fall_n[i] + 1;
        nb[i] <= 0;
      end
      if (!cs_prev[i] && cs_v[i] && len_n[i] < 64 && fall_n[i] > 0) begin
        cs_len[i][len_n[i]]       <= now_c() - fall_t[i][fall_n[i]-1];
        sclk_at_rise[i][len_n[i]] <= int'(sclk_v[i]);
        len_n[i] <= len_n[i] + 1;
        last_csrise[i] <= now_c();
      end
      if (!cs_v[i] && !sclk_prev[i] && sclk_v[i] && rise_n[i] < 2048) begin
        rise_t[i][rise_n[i]] <= now_c();
        rise_n[i] <= rise_n[i] + 1;
        if (nb[i] == 7) begin
          if (rx_n[i] < 256) rx_mem[i][rx_n[i]] <= {sh[i][6:0], mosi_v[i]};
          rx_n[i] <= rx_n[i] + 1;
          nb[i] <= 0;
        end else begin
          nb[i] <= nb[i] + 1;
        end
        sh[i] <= {sh[i][6:0], mosi_v[i]};
      end
      if (sclk_prev[i] && sclk_v[i] && (mosi_v[i] !== mosi_prev[i]))
        viol[i] <= viol[i] + 1;
    end
    cs_prev   <= cs_v;
    sclk_prev <= sclk_v;
    mosi_prev <= mosi_v;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int i);
    chk({tag, "_cs_n"},  int'(cs_v[i]),    1);
    chk({tag, "_sclk"},  int'(sclk_v[i]),  0);
    chk({tag, "_mosi"},  int'(mosi_v[i]),  0);
    chk({tag, "_busy"},  int'(busy_v[i]),  0);
    chk({tag, "_ready"}, int'(ready_v[i]), 1);
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  // acc = observation cycle of the accepting edge.
  task automatic send(input int i, input logic [7:0] d, input logic l, output int acc);
    int n;
    n = 0;
    acc = -1;
    valid_v[i] = 1'b1; data_v[i] = d; last_v[i] = l;
    while (acc < 0 && n < 3000) begin
      if (ready_v[i]) acc = now_c() + 1;
      @(negedge clk);
      n++;
    end
    valid_v[i] = 1'b0;
    if (acc < 0) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_frames(input int i, input int target);
    int n;
    n = 0;
    while ((len_n[i] < target || busy_v[i]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("frame_timeout", len_n[i], target);
    repeat (2) @(negedge clk);
  endtask

  int         acc, acc0, acc2, lb, rb, xb, fb, bad, nbytes, target;
  logic [7:0] bytes_q [$];

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0; valid_v = 2'b00; last_v = 2'b00;
    data_v[0] = 8'h00; data_v[1] = 8'h00;

    // Reset asserted between clock edges: outputs must go idle with no edge.
    #3 rst = 1'b1;
    #1;
    chk_idle("rst_async_a", 0);
    chk_idle("rst_async_b", 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_idle("post_rst_a", 0);
    chk_idle("post_rst_b", 1);

    // Single byte 0xA5, last, D=2
    lb = len_n[0]; rb = rise_n[0]; xb = rx_n[0]; fb = fall_n[0];
    send(0, 8'hA5, 1'b1, acc);
    wait_frames(0, lb + 1);
    chk("a5_cs_len", cs_len[0][lb], 34);
    chk("a5_rises", rise_n[0] - rb, 8);
    chk("a5_byte", int'(rx_mem[0][xb]), 8'hA5);
    chk("a5_sclk_at_csrise", sclk_at_rise[0][lb], 0);
    chk("a5_cs_fall_lat", fall_t[0][fb] - acc, 1);
    chk("a5_first_rise", rise_t[0][rb] - fall_t[0][fb], 2);
    chk("a5_ready_after", int'(ready_v[0]), 1);

    // Burst 0x01, 0x80, 0xFF, source always valid
    lb = len_n[0]; rb = rise_n[0]; xb = rx_n[0];
    send(0, 8'h01, 1'b0, acc);
    send(0, 8'h80, 1'b0, acc);
    send(0, 8'hFF, 1'b1, acc);
    wait_frames(0, lb + 1);
    chk("burst_rises", rise_n[0] - rb, 24);
    bad = 0;
    for (int k = 1; k < 24; k++)
      if (rise_t[0][rb+k] - rise_t[0][rb+k-1] != 4) bad++;
    chk("burst_spacing_bad", bad, 0);
    chk("burst_cs_len", cs_len[0][lb], 98);
    chk("burst_b0", int'(rx_mem[0][xb]),   8'h01);
    chk("burst_b1", int'(rx_mem[0][xb+1]), 8'h80);
    chk("burst_b2", int'(rx_mem[0][xb+2]), 8'hFF);

    // Underrun: second byte offered 20 cycles after the first boundary
    lb = len_n[0]; rb = rise_n[0]; xb = rx_n[0];
    send(0, 8'hC3, 1'b0, acc0);
    target = acc0 + 1 + 32 + 20;
    while (now_c() < target) @(negedge clk);
    chk("under_cs_low_wait", int'(cs_v[0]), 0);
    chk("under_sclk_low_wait", int'(sclk_v[0]), 0);
    chk("under_busy_wait", int'(busy_v[0]), 1);
    send(0, 8'h3C, 1'b1, acc2);
    wait_frames(0, lb + 1);
    chk("under_one_frame", len_n[0] - lb, 1);
    chk("under_rises", rise_n[0] - rb, 16);
    chk("under_first_rise_2nd", rise_t[0][rb+8], acc2 + 1 + 2);
    chk("under_cs_len", cs_len[0][lb], (acc2 + 1 + 34) - (acc0 + 1));
    chk("under_b0", int'(rx_mem[0][xb]),   8'hC3);
    chk("under_b1", int'(rx_mem[0][xb+1]), 8'h3C);

    // Reset after the 4th rising edge of 0xF0
    rb = rise_n[0]; xb = rx_n[0];
    send(0, 8'hF0, 1'b1, acc);
    bad = 0;
    while (rise_n[0] < rb + 4 && bad < 200) begin
      @(negedge clk);
      bad++;
    end
    chk("abort_reached_rise4", int'(rise_n[0] >= rb + 4), 1);
    #2 rst = 1'b1;
    #1;
    chk_idle("abort_rst", 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_cs_stays_high", int'(cs_v[0]), 1);
    lb = len_n[0]; rb = rise_n[0];
    send(0, 8'h5A, 1'b1, acc);
    wait_frames(0, lb + 1);
    chk("abort_next_rises", rise_n[0] - rb, 8);
    chk("abort_rx_count", rx_n[0] - xb, 1);
    chk("abort_next_byte", int'(rx_mem[0][xb]), 8'h5A);

    // Back-to-back single-byte frames on the D=1, GAP=3 instance
    lb = len_n[1]; xb = rx_n[1]; fb = fall_n[1];
    send(1, 8'h11, 1'b1, acc);
    send(1, 8'h22, 1'b1, acc);
    wait_frames(1, lb + 2);
    chk("b2b_len0", cs_len[1][lb], 17);
    chk("b2b_len1", cs_len[1][lb+1], 17);
    chk("b2b_gap_ge3", int'(gap_len[1][fb+1] >= 3), 1);
    chk("b2b_byte0", int'(rx_mem[1][xb]),   8'h11);
    chk("b2b_byte1", int'(rx_mem[1][xb+1]), 8'h22);

    // Randomized bursts against the receiver model
    for (int r = 0; r < 4; r++) begin
      nbytes = int'($urandom_range(1, 4));
      bytes_q.delete();
      for (int k = 0; k < nbytes; k++) bytes_q.push_back(8'($urandom));
      lb = len_n[0]; rb = rise_n[0]; xb = rx_n[0];
      for (int k = 0; k < nbytes; k++)
        send(0, bytes_q[k], (k == nbytes - 1), acc);
      wait_frames(0, lb + 1);
      chk($sformatf("rand%0d_cs_len", r), cs_len[0][lb], (16 * nbytes + 1) * 2);
      chk($sformatf("rand%0d_rises", r), rise_n[0] - rb, 8 * nbytes);
      bad = 0;
      for (int k = 0; k < nbytes; k++)
        if (rx_mem[0][xb+k] !== bytes_q[k]) bad++;
      chk($sformatf("rand%0d_bytes_bad", r), bad, 0);
    end

    chk("mosi_stable_sclk_high_a", viol[0], 0);
    chk("mosi_stable_sclk_high_b", viol[1], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
